// File: rtl/pes_rca_arbiter.sv
// pes_rca_arbiter
//   Round-robin arbiter that time-shares one registered 4-bit ripple-carry adder
//   between NUM_REQ requesters. One add is accepted per cycle through a
//   valid/ready handshake. The winning operands are driven to the adder in the
//   same cycle. The owner ID follows the op through an ADD_LAT-deep pipeline, so
//   the sum and carry are returned to the requester that issued the op.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid[NUM_REQ]    requester i has an add pending
//   req_a/req_b           4-bit operands, requester i in bits [4i+3:4i]
//   req_ready[NUM_REQ]    one-hot grant (handshake = valid & ready)
//   add_a/add_b           operands to the shared adder (0 when idle)
//   add_s/add_cout        adder result, ADD_LAT cycles after the operands
//   rsp_valid[NUM_REQ]    one-hot 1-cycle result pulse to the owner
//   rsp_sum/rsp_cout      result (0 when no pulse)
//   op_count              completed operations, wraps modulo 2^CNT_W

// Per-requester slice: grant/response decode and operand gating.
module pes_rca_arbiter_lane #(
    parameter int ID_W = 2,
    parameter int LANE = 0
) (
    input  logic            grant_vld,
    input  logic [ID_W-1:0] grant_id,
    input  logic            tail_vld,
    input  logic [ID_W-1:0] tail_id,
    input  logic [3:0]      a,
    input  logic [3:0]      b,
    output logic            ready,
    output logic            rsp,
    output logic [3:0]      a_gated,
    output logic [3:0]      b_gated
);
    localparam logic [ID_W-1:0] MY_ID = ID_W'(LANE);

    assign ready   = grant_vld && (grant_id == MY_ID);
    assign rsp     = tail_vld && (tail_id == MY_ID);
    // Gated operands are OR-ed across lanes, which forms a one-hot mux.
    assign a_gated = a & {4{ready}};
    assign b_gated = b & {4{ready}};
endmodule

module pes_rca_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    input  logic [3:0]           add_s,
    input  logic                 add_cout,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [3:0]           rsp_sum,
    output logic                 rsp_cout,
    output logic [CNT_W-1:0]     op_count
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int STAGES = ADD_LAT - 1;

    logic [ID_W-1:0]              rr_ptr;
    logic                         grant_vld;
    logic [ID_W-1:0]              grant_id;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:0][ID_W-1:0]    id_pipe;
    logic [NUM_REQ-1:0][3:0]      lane_a;
    logic [NUM_REQ-1:0][3:0]      lane_b;
    logic [NUM_REQ-1:0]           lane_rdy;
    logic [NUM_REQ-1:0]           lane_rsp;

    // (base + off) mod NUM_REQ; off < NUM_REQ, so one subtract suffices.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[ID_W-1:0];
    endfunction

    // Scan upward from rr_ptr with wrap; the first pending requester wins.
    // Forced idle while reset is held, so no grant can escape during reset.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && rst_n && req_valid[wrap_idx(rr_ptr, k)]) begin
                grant_vld = 1'b1;
                grant_id  = wrap_idx(rr_ptr, k);
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        pes_rca_arbiter_lane #(.ID_W(ID_W), .LANE(i)) u_lane (
            .grant_vld (grant_vld),
            .grant_id  (grant_id),
            .tail_vld  (vld_pipe[STAGES]),
            .tail_id   (id_pipe[STAGES]),
            .a         (req_a[4*i +: 4]),
            .b         (req_b[4*i +: 4]),
            .ready     (lane_rdy[i]),
            .rsp       (lane_rsp[i]),
            .a_gated   (lane_a[i]),
            .b_gated   (lane_b[i])
        );
    end

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            add_a = add_a | lane_a[i];
            add_b = add_b | lane_b[i];
        end
    end

    assign req_ready = lane_rdy;
    assign rsp_valid = lane_rsp;
    assign rsp_sum   = vld_pipe[STAGES] ? add_s : 4'd0;
    assign rsp_cout  = vld_pipe[STAGES] & add_cout;

    // Owner-ID pipeline matches the adder latency; no stalls, so a plain
    // shift register keeps ops in order at one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            vld_pipe <= '0;
            id_pipe  <= '0;
            op_count <= '0;
        end else begin
            vld_pipe[0] <= grant_vld;
            id_pipe[0]  <= grant_id;
            for (int s = 1; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
            if (grant_vld) rr_ptr <= wrap_idx(grant_id, 1);
            if (vld_pipe[STAGES]) op_count <= op_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pes_rca_arbiter.sv
// Bench for pes_rca_arbiter. dut1 uses NUM_REQ=4, ADD_LAT=1 and CNT_W=16.
// dut2 uses ADD_LAT=3 and CNT_W=3, so a mid-op reset and counter wrap are
// reachable in a few cycles. The shared adder is modelled here as a registered
// adder with the matching latency.
module tb_pes_rca_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- dut1: ADD_LAT=1 ----------------
    logic        rst_n = 1'b0;
    logic [3:0]  v1 = '0;
    logic [15:0] a1 = '0, b1 = '0;
    logic [3:0]  rdy1, aa1, ab1, s1, rv1, rs1;
    logic        c1, rc1;
    logic [15:0] oc1;
    logic [4:0]  sp1 = '0;

    always_ff @(posedge clk) sp1 <= 5'(aa1) + 5'(ab1);
    assign {c1, s1} = sp1;

    pes_rca_arbiter #(.NUM_REQ(4), .ADD_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_a(a1), .req_b(b1),
        .req_ready(rdy1), .add_a(aa1), .add_b(ab1), .add_s(s1), .add_cout(c1),
        .rsp_valid(rv1), .rsp_sum(rs1), .rsp_cout(rc1), .op_count(oc1));

    // ---------------- dut2: ADD_LAT=3, CNT_W=3 ----------------
    logic        rst2_n = 1'b0;
    logic [3:0]  v2 = '0;
    logic [15:0] a2 = '0, b2 = '0;
    logic [3:0]  rdy2, aa2, ab2, s2, rv2, rs2;
    logic        c2, rc2;
    logic [2:0]  oc2;
    logic [4:0]  sp2 [3];

    always_ff @(posedge clk) begin
        sp2[0] <= 5'(aa2) + 5'(ab2);
        sp2[1] <= sp2[0];
        sp2[2] <= sp2[1];
    end
    assign {c2, s2} = sp2[2];

    pes_rca_arbiter #(.NUM_REQ(4), .ADD_LAT(3), .CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst2_n), .req_valid(v2), .req_a(a2), .req_b(b2),
        .req_ready(rdy2), .add_a(aa2), .add_b(ab2), .add_s(s2), .add_cout(c2),
        .rsp_valid(rv2), .rsp_sum(rs2), .rsp_cout(rc2), .op_count(oc2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [15:0] a, b;
        logic [3:0]  rdy, ea, eb, rv, rs;
        logic        rc;
    } vec_t;

    typedef struct {
        int         due;
        int         id;
        logic [4:0] res;
    } rsp_t;

    // Check every dut1 output while reset is held with toggling inputs.
    task automatic reset1();
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            v1 = 4'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
            #1;
            chk("rst_ready", 32'(rdy1), 0);
            chk("rst_add_a", 32'(aa1), 0);
            chk("rst_add_b", 32'(ab1), 0);
            chk("rst_rsp_valid", 32'(rv1), 0);
            chk("rst_rsp_sum", 32'(rs1), 0);
            chk("rst_rsp_cout", 32'(rc1), 0);
            chk("rst_op_count", 32'(oc1), 0);
            @(negedge clk);
        end
        rst_n = 1'b1; v1 = '0; a1 = '0; b1 = '0;
        #1;
        chk("post_rst_ready", 32'(rdy1), 0);
        chk("post_rst_op_count", 32'(oc1), 0);
    endtask

    vec_t tbl [18];

    initial begin
        // Directed sequence from reset (rr_ptr=0).
        tbl[0]  = '{4'b0001, 16'h0008, 16'h0008, 4'b0001, 4'h8, 4'h8, 4'b0000, 4'h0, 1'b0};
        tbl[1]  = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'h0, 4'h0, 4'b0001, 4'h0, 1'b1};
        tbl[2]  = '{4'b0001, 16'h000F, 16'h000F, 4'b0001, 4'hF, 4'hF, 4'b0000, 4'h0, 1'b0};
        tbl[3]  = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'h0, 4'h0, 4'b0001, 4'hE, 1'b1};
        tbl[4]  = '{4'b1000, 16'h3210, 16'h5555, 4'b1000, 4'h3, 4'h5, 4'b0000, 4'h0, 1'b0};
        tbl[5]  = '{4'b1111, 16'h3210, 16'h5555, 4'b0001, 4'h0, 4'h5, 4'b1000, 4'h8, 1'b0};
        tbl[6]  = '{4'b1111, 16'h3210, 16'h5555, 4'b0010, 4'h1, 4'h5, 4'b0001, 4'h5, 1'b0};
        tbl[7]  = '{4'b1111, 16'h3210, 16'h5555, 4'b0100, 4'h2, 4'h5, 4'b0010, 4'h6, 1'b0};
        tbl[8]  = '{4'b1111, 16'h3210, 16'h5555, 4'b1000, 4'h3, 4'h5, 4'b0100, 4'h7, 1'b0};
        tbl[9]  = '{4'b1111, 16'h3210, 16'h5555, 4'b0001, 4'h0, 4'h5, 4'b1000, 4'h8, 1'b0};
        tbl[10] = '{4'b1111, 16'h3210, 16'h5555, 4'b0010, 4'h1, 4'h5, 4'b0001, 4'h5, 1'b0};
        tbl[11] = '{4'b1111, 16'h3210, 16'h5555, 4'b0100, 4'h2, 4'h5, 4'b0010, 4'h6, 1'b0};
        tbl[12] = '{4'b1111, 16'h3210, 16'h5555, 4'b1000, 4'h3, 4'h5, 4'b0100, 4'h7, 1'b0};
        tbl[13] = '{4'b0101, 16'h3210, 16'h5555, 4'b0001, 4'h0, 4'h5, 4'b1000, 4'h8, 1'b0};
        tbl[14] = '{4'b0101, 16'h3210, 16'h5555, 4'b0100, 4'h2, 4'h5, 4'b0001, 4'h5, 1'b0};
        tbl[15] = '{4'b0101, 16'h3210, 16'h5555, 4'b0001, 4'h0, 4'h5, 4'b0100, 4'h7, 1'b0};
        tbl[16] = '{4'b0101, 16'h3210, 16'h5555, 4'b0100, 4'h2, 4'h5, 4'b0001, 4'h5, 1'b0};
        tbl[17] = '{4'b0000, 16'h0000, 16'h0000, 4'b0000, 4'h0, 4'h0, 4'b0100, 4'h7, 1'b0};

        reset1();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            v1 = tbl[i].v; a1 = tbl[i].a; b1 = tbl[i].b;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(rdy1), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_add_a", i), 32'(aa1), 32'(tbl[i].ea));
            chk($sformatf("tbl%0d_add_b", i), 32'(ab1), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d_rsp_valid", i), 32'(rv1), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_rsp_sum", i), 32'(rs1), 32'(tbl[i].rs));
            chk($sformatf("tbl%0d_rsp_cout", i), 32'(rc1), 32'(tbl[i].rc));
        end
        @(negedge clk);
        #1;
        chk("tbl_op_count", 32'(oc1), 15);
        chk("tbl_idle_rsp", 32'(rv1), 0);

        // Randomized traffic on dut1 against a queue-based reference model.
        begin
            int         ptr, ops, g;
            bit         pend [N];
            logic [3:0] pa [N], pb [N];
            logic [3:0] erv, ers;
            logic       erc;
            rsp_t       q [$];
            reset1();
            ptr = 0; ops = 0;
            for (int i = 0; i < N; i++) pend[i] = 1'b0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                for (int i = 0; i < N; i++) begin
                    if (!pend[i] && cyc < 395 && $urandom_range(0, 1) == 1) begin
                        pend[i] = 1'b1;
                        pa[i] = 4'($urandom);
                        pb[i] = 4'($urandom);
                    end
                    v1[i]       = pend[i];
                    a1[4*i +: 4] = pend[i] ? pa[i] : 4'($urandom);
                    b1[4*i +: 4] = pend[i] ? pb[i] : 4'($urandom);
                end
                #1;
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
                chk("rnd_ready", 32'(rdy1), (g >= 0) ? (1 << g) : 0);
                chk("rnd_add_a", 32'(aa1), (g >= 0) ? 32'(pa[g]) : 0);
                chk("rnd_add_b", 32'(ab1), (g >= 0) ? 32'(pb[g]) : 0);
                erv = '0; ers = '0; erc = 1'b0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    erv = 4'(1 << q[0].id);
                    {erc, ers} = q[0].res;
                end
                chk("rnd_rsp_valid", 32'(rv1), 32'(erv));
                chk("rnd_rsp_sum", 32'(rs1), 32'(ers));
                chk("rnd_rsp_cout", 32'(rc1), 32'(erc));
                chk("rnd_op_count", 32'(oc1), 32'(16'(ops)));
                if (erv != 0) begin
                    void'(q.pop_front());
                    ops++;
                end
                if (g >= 0) begin
                    pend[g] = 1'b0;
                    ptr = (g + 1) % N;
                    q.push_back('{due: cyc + 1, id: g, res: 5'(pa[g]) + 5'(pb[g])});
                end
            end
        end

        // dut2: handshake, then a reset pulse one cycle later discards the op.
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        v2 = 4'b0010; a2 = 16'h0010; b2 = 16'h0010;
        #1;
        chk("mid_rst_grant", 32'(rdy2), 32'b0010);
        @(negedge clk);
        v2 = '0; rst2_n = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk("mid_rst_no_rsp", 32'(rv2), 0);
            chk("mid_rst_op_count", 32'(oc2), 0);
        end
        // rr_ptr is back at 0, so requester 1 beats requester 3.
        @(negedge clk);
        v2 = 4'b1010; a2 = 16'h1010; b2 = 16'h1010;
        #1;
        chk("post_rst_grant", 32'(rdy2), 32'b0010);
        chk("post_rst_add_a", 32'(aa2), 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            v2 = '0;
            #1;
            chk("lat3_rsp_valid", 32'(rv2), (k == 3) ? 32'b0010 : 0);
            chk("lat3_rsp_sum", 32'(rs2), (k == 3) ? 2 : 0);
        end
        chk("lat3_op_count", 32'(oc2), 1);

        // dut2: back-to-back issue with all requesters valid; counter wraps 7 -> 0.
        begin
            int         ptr2, ops2, g;
            logic [3:0] erv;
            logic [4:0] eres;
            rsp_t       q2 [$];
            ptr2 = 2; ops2 = 1;
            a2 = 16'($urandom); b2 = 16'($urandom);
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                v2 = (c < 8) ? 4'b1111 : 4'b0000;
                #1;
                g = (c < 8) ? ptr2 : -1;
                chk("wrap_ready", 32'(rdy2), (g >= 0) ? (1 << g) : 0);
                chk("wrap_add_a", 32'(aa2), (g >= 0) ? 32'(a2[4*g +: 4]) : 0);
                erv = '0; eres = '0;
                if (q2.size() > 0 && q2[0].due == c) begin
                    erv = 4'(1 << q2[0].id);
                    eres = q2[0].res;
                end
                chk("wrap_rsp_valid", 32'(rv2), 32'(erv));
                chk("wrap_rsp_res", 32'({rc2, rs2}), 32'(eres));
                chk("wrap_op_count", 32'(oc2), ops2 % 8);
                if (erv != 0) begin
                    void'(q2.pop_front());
                    ops2++;
                end
                if (g >= 0) begin
                    ptr2 = (g + 1) % N;
                    q2.push_back('{due: c + 3, id: g,
                                   res: 5'(a2[4*g +: 4]) + 5'(b2[4*g +: 4])});
                end
            end
            chk("wrap_total_ops", 32'(ops2), 9);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
